// File: rtl/gpu_gfx_pkg.sv
// Shared graphics definitions: default resolution, pixel/address types and the
// fill-engine state encoding.
package gpu_gfx_pkg;

  localparam int unsigned H_RES_DEFAULT   = 640;
  localparam int unsigned V_RES_DEFAULT   = 480;
  localparam int unsigned COORD_W_DEFAULT = 10;
  localparam int unsigned ADDR_W_DEFAULT  = 19;
  localparam int unsigned PIX_W_DEFAULT   = 24;

  typedef logic [PIX_W_DEFAULT-1:0]  pixel_t;
  typedef logic [ADDR_W_DEFAULT-1:0] fb_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ERR
  } fill_state_t;

endpackage

// File: rtl/gpu_fill_engine_if.sv
// Fill-request, rasterizer and framebuffer-write signals of the fill engine.
// The master drives requests and rasterizer writes; the slave is the engine.
interface gpu_fill_engine_if
  import gpu_gfx_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned PIX_W   = PIX_W_DEFAULT
);

  logic               fill_start;
  logic               fill_abort;
  logic [COORD_W-1:0] fill_x0;
  logic [COORD_W-1:0] fill_y0;
  logic [COORD_W-1:0] fill_x1;
  logic [COORD_W-1:0] fill_y1;
  logic [PIX_W-1:0]   fill_color;
  logic               fill_busy;
  logic               fill_done;
  logic               fill_err;
  logic [ADDR_W-1:0]  rast_addr;
  logic [PIX_W-1:0]   rast_data;
  logic               rast_write;
  logic [ADDR_W-1:0]  fb_wr_addr;
  logic [PIX_W-1:0]   fb_wr_data;
  logic               fb_wr_enable;

  modport master (
    output fill_start, fill_abort, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    output rast_addr, rast_data, rast_write,
    input  fill_busy, fill_done, fill_err,
    input  fb_wr_addr, fb_wr_data, fb_wr_enable
  );

  modport slave (
    input  fill_start, fill_abort, fill_x0, fill_y0, fill_x1, fill_y1, fill_color,
    input  rast_addr, rast_data, rast_write,
    output fill_busy, fill_done, fill_err,
    output fb_wr_addr, fb_wr_data, fb_wr_enable
  );

endinterface

// File: rtl/fb_write_arbiter.sv
// Fixed-priority 2:1 framebuffer write mux (rasterizer over fill) with the
// registered write port.
module fb_write_arbiter #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 24
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rast_write_i,
  input  logic [ADDR_W-1:0] rast_addr_i,
  input  logic [PIX_W-1:0]  rast_data_i,
  input  logic              fill_req_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [PIX_W-1:0]  fill_data_i,
  output logic              fill_gnt_o,
  output logic [ADDR_W-1:0] fb_wr_addr_o,
  output logic [PIX_W-1:0]  fb_wr_data_o,
  output logic              fb_wr_enable_o
);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [PIX_W-1:0]  data_d, data_q;
  logic              en_d, en_q;

  always_comb begin
    fill_gnt_o = ~rast_write_i;
    addr_d     = addr_q;
    data_d     = data_q;
    en_d       = 1'b0;
    if (rast_write_i) begin
      addr_d = rast_addr_i;
      data_d = rast_data_i;
      en_d   = 1'b1;
    end else if (fill_req_i) begin
      addr_d = fill_addr_i;
      data_d = fill_data_i;
      en_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      data_q <= '0;
      en_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  assign fb_wr_addr_o   = addr_q;
  assign fb_wr_data_o   = data_q;
  assign fb_wr_enable_o = en_q;

endmodule

// File: rtl/gpu_fill_engine.sv
// Rectangle-fill engine: request clamping/validation, raster-order pixel
// counters and the fill FSM, feeding the shared framebuffer write arbiter.
module gpu_fill_engine
  import gpu_gfx_pkg::*;
#(
  parameter int unsigned H_RES   = H_RES_DEFAULT,
  parameter int unsigned V_RES   = V_RES_DEFAULT,
  parameter int unsigned COORD_W = COORD_W_DEFAULT,
  parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
  parameter int unsigned PIX_W   = PIX_W_DEFAULT
) (
  input logic               clk_sys,
  input logic               rst_n,
  gpu_fill_engine_if.slave  fe_if
);

  localparam logic [COORD_W-1:0] XMax     = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YMax     = COORD_W'(V_RES - 1);
  localparam logic [ADDR_W-1:0]  HResAddr = ADDR_W'(H_RES);

  fill_state_t        state_d, state_q;
  logic [COORD_W-1:0] x0_d, x0_q, x1_d, x1_q, y1_d, y1_q;
  logic [COORD_W-1:0] cx_d, cx_q, cy_d, cy_q;
  logic [ADDR_W-1:0]  row_base_d, row_base_q;
  logic [PIX_W-1:0]   color_d, color_q;

  logic [COORD_W-1:0] x1_clamp, y1_clamp;
  logic               req_bad;
  logic               fill_req, fill_gnt, last_pix;
  logic [ADDR_W-1:0]  fill_addr;

  assign fill_req  = (state_q == RUN);
  assign fill_addr = row_base_q + ADDR_W'(cx_q);
  assign last_pix  = (cx_q == x1_q) && (cy_q == y1_q);

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    row_base_d = row_base_q;
    color_d    = color_q;

    x1_clamp = (fe_if.fill_x1 > XMax) ? XMax : fe_if.fill_x1;
    y1_clamp = (fe_if.fill_y1 > YMax) ? YMax : fe_if.fill_y1;
    req_bad  = (fe_if.fill_x0 > x1_clamp) || (fe_if.fill_y0 > y1_clamp) ||
               (fe_if.fill_x0 > XMax) || (fe_if.fill_y0 > YMax);

    unique case (state_q)
      IDLE: begin
        if (fe_if.fill_start) begin
          x0_d       = fe_if.fill_x0;
          x1_d       = x1_clamp;
          y1_d       = y1_clamp;
          cx_d       = fe_if.fill_x0;
          cy_d       = fe_if.fill_y0;
          row_base_d = ADDR_W'(fe_if.fill_y0) * HResAddr;
          color_d    = fe_if.fill_color;
          state_d    = req_bad ? ERR : RUN;
        end
      end
      RUN: begin
        // Counters only move on cycles where the arbiter took the fill pixel.
        if (fill_gnt) begin
          if (last_pix) begin
            state_d = DONE;
          end
          if (cx_q == x1_q) begin
            cx_d       = x0_q;
            cy_d       = cy_q + COORD_W'(1);
            row_base_d = row_base_q + HResAddr;
          end else begin
            cx_d = cx_q + COORD_W'(1);
          end
        end
        if (fe_if.fill_abort) begin
          state_d = IDLE;
        end
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      row_base_q <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      row_base_q <= row_base_d;
      color_q    <= color_d;
    end
  end

  assign fe_if.fill_busy = (state_q == RUN);
  assign fe_if.fill_done = (state_q == DONE);
  assign fe_if.fill_err  = (state_q == ERR);

  fb_write_arbiter #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_arb (
    .clk_i          (clk_sys),
    .rst_ni         (rst_n),
    .rast_write_i   (fe_if.rast_write),
    .rast_addr_i    (fe_if.rast_addr),
    .rast_data_i    (fe_if.rast_data),
    .fill_req_i     (fill_req),
    .fill_addr_i    (fill_addr),
    .fill_data_i    (color_q),
    .fill_gnt_o     (fill_gnt),
    .fb_wr_addr_o   (fe_if.fb_wr_addr),
    .fb_wr_data_o   (fe_if.fb_wr_data),
    .fb_wr_enable_o (fe_if.fb_wr_enable)
  );

endmodule

// File: tb/tb_gpu_fill_engine.sv
// Scoreboard bench for gpu_fill_engine: a rectangle model enumerates expected
// pixels per request, a monitor checks every framebuffer write as it appears.
module tb_gpu_fill_engine;

  localparam int HRes = 640;
  localparam int VRes = 480;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  gpu_fill_engine_if #(.COORD_W(10), .ADDR_W(19), .PIX_W(24)) fe_if ();

  gpu_fill_engine #(
    .H_RES   (HRes),
    .V_RES   (VRes),
    .COORD_W (10),
    .ADDR_W  (19),
    .PIX_W   (24)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .fe_if   (fe_if)
  );

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every visible write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_sys);
      if (fe_if.fb_wr_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", fe_if.fb_wr_addr, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", fe_if.fb_wr_addr, e.addr);
          chk("wr_data", fe_if.fb_wr_data, e.data);
          chk("wr_cycle", cyc, e.cyc);
          chk("done_align", fe_if.fill_done, e.last);
        end
      end else begin
        chk("done_without_write", fe_if.fill_done, 0);
      end
    end
  end

  task automatic rast_cycle(input int prob, input bit force_it, output bit used);
    used = force_it || ($urandom_range(0, 99) < prob);
    fe_if.rast_write = used;
    if (used) begin
      fe_if.rast_addr = force_it ? 19'h00100 : 19'($urandom);
      fe_if.rast_data = 24'($urandom);
      exp_q.push_back('{addr: fe_if.rast_addr, data: fe_if.rast_data, last: 1'b0,
                        cyc: cyc + 1});
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_enable"}, fe_if.fb_wr_enable, 0);
    chk({tag, "_wr_addr"}, fe_if.fb_wr_addr, 0);
    chk({tag, "_wr_data"}, fe_if.fb_wr_data, 0);
    chk({tag, "_busy"}, fe_if.fill_busy, 0);
    chk({tag, "_done"}, fe_if.fill_done, 0);
    chk({tag, "_err"}, fe_if.fill_err, 0);
  endtask

  // One fill request: the model lists the clamped rectangle in raster order and
  // each RUN cycle either yields to a rasterizer write or consumes one pixel.
  task automatic run_fill(input int x0, input int y0, input int x1, input int y1,
                          input logic [23:0] color, input int rast_prob,
                          input int force_lo, input int force_hi,
                          input int abort_at, input int reset_at, input bit noise);
    int          x1c, y1c, run;
    bit          bad, aborted, used, abort_now;
    logic [18:0] pix[$];
    x1c = (x1 > HRes - 1) ? HRes - 1 : x1;
    y1c = (y1 > VRes - 1) ? VRes - 1 : y1;
    bad = (x0 > x1c) || (y0 > y1c) || (x0 >= HRes) || (y0 >= VRes);
    if (!bad)
      for (int y = y0; y <= y1c; y++)
        for (int x = x0; x <= x1c; x++) pix.push_back(19'(y * HRes + x));

    fe_if.fill_x0    = 10'(x0);
    fe_if.fill_y0    = 10'(y0);
    fe_if.fill_x1    = 10'(x1);
    fe_if.fill_y1    = 10'(y1);
    fe_if.fill_color = color;
    fe_if.fill_start = 1'b1;
    fe_if.rast_write = 1'b0;
    next_cycle();
    fe_if.fill_start = 1'b0;

    if (bad) begin
      chk("err_pulse", fe_if.fill_err, 1);
      chk("err_busy", fe_if.fill_busy, 0);
      rast_cycle(rast_prob, 1'b0, used);
      next_cycle();
      fe_if.rast_write = 1'b0;
      chk("err_clear", fe_if.fill_err, 0);
      chk("err_then_idle", fe_if.fill_busy, 0);
      return;
    end

    run = 0;
    aborted = 1'b0;
    while (pix.size() > 0 && !aborted) begin
      run++;
      chk("busy_run", fe_if.fill_busy, 1);
      if (run == reset_at) begin
        rst_n            = 1'b0;
        fe_if.rast_write = 1'b0;
        fe_if.fill_start = 1'b0;
        next_cycle();
        check_reset_outputs("reset_mid_fill");
        rst_n = 1'b1;
        return;
      end
      if (noise && ($urandom_range(0, 3) == 0)) begin
        fe_if.fill_start = 1'b1;
        fe_if.fill_x0    = 10'($urandom);
        fe_if.fill_y0    = 10'($urandom);
        fe_if.fill_x1    = 10'($urandom);
        fe_if.fill_y1    = 10'($urandom);
        fe_if.fill_color = ~color;
      end else begin
        fe_if.fill_start = 1'b0;
      end
      abort_now = (run == abort_at);
      fe_if.fill_abort = abort_now;
      rast_cycle(rast_prob, (run >= force_lo) && (run <= force_hi), used);
      if (!used) begin
        logic [18:0] a;
        a = pix.pop_front();
        exp_q.push_back('{addr: a, data: color, last: (pix.size() == 0) && !abort_now,
                          cyc: cyc + 1});
      end
      aborted = abort_now;
      next_cycle();
    end
    fe_if.fill_abort = 1'b0;
    fe_if.fill_start = 1'b0;
    fe_if.rast_write = 1'b0;
    chk("busy_end", fe_if.fill_busy, 0);
    chk("no_err_on_fill", fe_if.fill_err, 0);
    rast_cycle(rast_prob, 1'b0, used);
    next_cycle();
    fe_if.rast_write = 1'b0;
    chk("idle_after_fill", fe_if.fill_busy, 0);
  endtask

  initial begin
    bit used;
    fe_if.fill_start = 1'b0;
    fe_if.fill_abort = 1'b0;
    fe_if.fill_x0    = '0;
    fe_if.fill_y0    = '0;
    fe_if.fill_x1    = '0;
    fe_if.fill_y1    = '0;
    fe_if.fill_color = '0;
    fe_if.rast_addr  = '0;
    fe_if.rast_data  = '0;
    fe_if.rast_write = 1'b0;
    rst_n = 1'b0;
    repeat (3) next_cycle();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    next_cycle();

    // Rasterizer writes with nothing else going on.
    for (int i = 0; i < 10; i++) begin
      rast_cycle(50, 1'b0, used);
      next_cycle();
    end
    fe_if.rast_write = 1'b0;
    next_cycle();

    run_fill(10, 5, 12, 6, 24'hA5A5A5, 0, 0, -1, -1, -1, 1'b0);
    run_fill(10, 5, 12, 6, 24'h123456, 0, 2, 3, -1, -1, 1'b0);
    run_fill(630, 470, 700, 900, 24'h00FF00, 0, 0, -1, -1, -1, 1'b0);
    run_fill(5, 0, 3, 0, 24'hFF0000, 0, 0, -1, -1, -1, 1'b0);
    run_fill(650, 0, 700, 0, 24'hFF0000, 30, 0, -1, -1, -1, 1'b0);
    run_fill(0, 480, 10, 500, 24'hFF0000, 30, 0, -1, -1, -1, 1'b0);
    run_fill(0, 0, 9, 9, 24'h0F0F0F, 0, 0, -1, 3, -1, 1'b0);
    run_fill(1, 1, 2, 1, 24'h777777, 0, 0, -1, 2, -1, 1'b0);
    run_fill(0, 0, 639, 479, 24'h102030, 0, 0, -1, -1, 20, 1'b0);
    run_fill(100, 100, 105, 103, 24'hC0FFEE, 20, 0, -1, -1, -1, 1'b1);
    run_fill(0, 470, 639, 479, 24'h102030, 10, 0, -1, -1, -1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int rx0, ry0, rx1, ry1, ab;
      rx0 = $urandom_range(0, 650);
      ry0 = $urandom_range(0, 490);
      rx1 = rx0 + $urandom_range(0, 12) - 2;
      ry1 = ry0 + $urandom_range(0, 6) - 1;
      if (rx1 < 0) rx1 = 0;
      if (ry1 < 0) ry1 = 0;
      if (rx1 > 1023) rx1 = 1023;
      if (ry1 > 1023) ry1 = 1023;
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : -1;
      run_fill(rx0, ry0, rx1, ry1, 24'($urandom), 25, 0, -1, ab, -1,
               1'($urandom_range(0, 1)));
    end

    repeat (3) next_cycle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
